rsa_job_ctrl: RTL

RSA_JOB_CTRL -- requirements
Module: rsa_job_ctrl

---
 rtl/rsa_ctrl_pkg.sv | 34 +++
 rtl/rsa_rr_arb2.sv | 41 ++++
 rtl/rsa_job_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa_ctrl_pkg.sv
// rsa_ctrl_pkg -- shared definitions for the RSA job controller.
//
// Contents:
//   state_t          FSM state encoding (exposed on rsa_job_ctrl.state_dbg)
//   REQ_ENC/REQ_DEC  requester IDs (0 = encrypt, 1 = decrypt)
//   DEF_SETTLE_CYC   default settle window after an engine start pulse
//   DEF_TIMEOUT_CYC  default per-phase wait limit (timeout build only)
//   sel_exponent     exponent chosen for a requester

package rsa_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PK_RUN = 3'd1,
        ST_SK_RUN = 3'd2,
        ST_READY  = 3'd3,
        ST_ME_RUN = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    localparam logic REQ_ENC = 1'b0;
    localparam logic REQ_DEC = 1'b1;

    localparam int DEF_SETTLE_CYC  = 2;
    localparam int DEF_TIMEOUT_CYC = 1023;

    // Encrypt requests use the public exponent, decrypt requests the private one.
    function automatic logic [15:0] sel_exponent(input logic id,
                                                 input logic [7:0] e,
                                                 input logic [15:0] d);
        return (id == REQ_DEC) ? d : {8'h00, e};
    endfunction

endpackage

// File: rtl/rsa_rr_arb2.sv
// rsa_rr_arb2 -- two-requester round-robin arbiter.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   req[1:0]    request bits
//   advance     arbitration is being taken this cycle; rotate the pointer
//   gnt[1:0]    combinational one-hot (or zero) grant
//
// After reset requester 0 is favoured. Once requester k wins an advancing
// arbitration, requester 1-k is favoured next. A lone requester always wins.

module rsa_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio = 1 means requester 1 wins a tie.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            // Winner 0 hands priority to 1 and vice versa.
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/rsa_job_ctrl.sv
// rsa_job_ctrl -- sequences RSA key generation and arbitrates encrypt/decrypt
// jobs onto a single modular-exponentiation engine.
//
// Optional feature macro: RSA_JOB_CTRL_TIMEOUT_EN
//   defined   : a wait in PK_RUN/SK_RUN/ME_RUN longer than TIMEOUT_CYC cycles
//               ends with a one-cycle error response
//   undefined : waits are unbounded, no timeout counter is built
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   p, q, key_start           primes and one-cycle key generation request
//   key_done, pub_e,
//   priv_d, mod_n             key material, valid while key_done=1
//   req_valid[1:0]            bit0 encrypt, bit1 decrypt request levels
//   req_msg0, req_msg1        messages for requesters 0 and 1
//   req_gnt[1:0]              one-hot one-cycle acceptance
//   resp_valid, resp_id,
//   resp_data, resp_err       one-cycle result strobe with requester and status
//   pk_/sk_/me_start          engine start pulses (never two at once)
//   pk_/sk_/me_finish         engine done levels
//   pk_e, sk_d, sk_n          key engine results
//   me_msg, me_exp, me_mod,
//   me_result                 modexp operands (stable in ME_RUN) and result
//   state_dbg                 current FSM state
//   primes_dbg                {p, q} latched on the last key_start
//
// Handshake: a requester raises req_valid[k] with req_msg<k> and holds both
// until it sees req_gnt[k] high for one cycle; that cycle is the acceptance.
// Its result arrives later as exactly one resp_valid cycle with resp_id = k.

module rsa_job_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  p,
    input  logic [7:0]  q,
    input  logic        key_start,
    output logic        key_done,
    output logic [7:0]  pub_e,
    output logic [15:0] priv_d,
    output logic [15:0] mod_n,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_msg0,
    input  logic [15:0] req_msg1,
    output logic [1:0]  req_gnt,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [15:0] resp_data,
    output logic        resp_err,
    output logic        pk_start,
    output logic        sk_start,
    output logic        me_start,
    input  logic        pk_finish,
    input  logic        sk_finish,
    input  logic        me_finish,
    input  logic [7:0]  pk_e,
    input  logic [15:0] sk_d,
    input  logic [15:0] sk_n,
    output logic [15:0] me_msg,
    output logic [15:0] me_exp,
    output logic [15:0] me_mod,
    input  logic [15:0] me_result,
    output logic [2:0]  state_dbg,
    output logic [15:0] primes_dbg
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [7:0]    p_r;
    logic [7:0]    q_r;
    logic          gnt_id;
    logic          job_bad;    // granted job fails operand checks, skip engine
    logic          key_abort;  // RESP was caused by a key-phase timeout
    logic          tmo_hit;

    logic [1:0]    arb_req;
    logic [1:0]    arb_gnt;
    logic          arb_adv;
    logic          sel_id;
    logic [15:0]   sel_msg;
    logic [15:0]   sel_exp;
    logic          sel_bad;
    logic          settle_done;

    assign state_dbg   = state;
    assign primes_dbg  = {p_r, q_r};
    assign settle_done = (settle_cnt == '0);

    // key_start in READY takes precedence over pending requests.
    assign arb_adv = (state == ST_READY) && !key_start;
    assign arb_req = arb_adv ? req_valid : 2'b00;

    rsa_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

    always_comb begin
        sel_id  = arb_gnt[1] ? REQ_DEC : REQ_ENC;
        sel_msg = (sel_id == REQ_DEC) ? req_msg1 : req_msg0;
        sel_exp = sel_exponent(sel_id, pub_e, priv_d);
        sel_bad = (sel_msg >= mod_n) || (sel_exp == 16'h0000);
    end

`ifdef RSA_JOB_CTRL_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [TW-1:0] tmo_cnt;
    logic          in_wait;
    logic          any_start;

    assign in_wait   = (state == ST_PK_RUN) || (state == ST_SK_RUN) ||
                       (state == ST_ME_RUN);
    assign any_start = pk_start | sk_start | me_start;

    // The start-pulse cycle is wait cycle 1, so the counter may hold a stale
    // value from the previous phase only while the start pulse masks it.
    always_ff @(posedge clk) begin
        if (rst || !in_wait) begin
            tmo_cnt <= '0;
        end else if (any_start) begin
            tmo_cnt <= TW'(1);
        end else if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    assign tmo_hit = in_wait && !any_start && (tmo_cnt == TW'(TIMEOUT_CYC));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            p_r        <= '0;
            q_r        <= '0;
            gnt_id     <= 1'b0;
            job_bad    <= 1'b0;
            key_abort  <= 1'b0;
            key_done   <= 1'b0;
            pub_e      <= '0;
            priv_d     <= '0;
            mod_n      <= '0;
            req_gnt    <= 2'b00;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            pk_start   <= 1'b0;
            sk_start   <= 1'b0;
            me_start   <= 1'b0;
            me_msg     <= '0;
            me_exp     <= '0;
            me_mod     <= '0;
        end else begin
            // Pulses default low every cycle.
            pk_start   <= 1'b0;
            sk_start   <= 1'b0;
            me_start   <= 1'b0;
            req_gnt    <= 2'b00;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;

            if (!settle_done) begin
                settle_cnt <= settle_cnt - SW'(1);
            end

            case (state)
                ST_IDLE, ST_READY: begin
                    if (key_start) begin
                        p_r        <= p;
                        q_r        <= q;
                        key_done   <= 1'b0;
                        pk_start   <= 1'b1;
                        settle_cnt <= SW'(SETTLE_CYC);
                        state      <= ST_PK_RUN;
                    end else if ((state == ST_READY) && (arb_gnt != 2'b00)) begin
                        req_gnt <= arb_gnt;
                        gnt_id  <= sel_id;
                        me_msg  <= sel_msg;
                        me_exp  <= sel_exp;
                        me_mod  <= mod_n;
                        job_bad <= sel_bad;
                        if (!sel_bad) begin
                            me_start   <= 1'b1;
                            settle_cnt <= SW'(SETTLE_CYC);
                        end
                        state <= ST_ME_RUN;
                    end
                end

                ST_PK_RUN: begin
                    if (settle_done && pk_finish) begin
                        pub_e      <= pk_e;
                        sk_start   <= 1'b1;
                        settle_cnt <= SW'(SETTLE_CYC);
                        state      <= ST_SK_RUN;
                    end else if (tmo_hit) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_id    <= 1'b0;
                        resp_data  <= '0;
                        key_abort  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end

                ST_SK_RUN: begin
                    if (settle_done && sk_finish) begin
                        priv_d   <= sk_d;
                        mod_n    <= sk_n;
                        key_done <= 1'b1;
                        state    <= ST_READY;
                    end else if (tmo_hit) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_id    <= 1'b0;
                        resp_data  <= '0;
                        key_abort  <= 1'b1;
                        state      <= ST_RESP;
                    end
                end

                ST_ME_RUN: begin
                    if (job_bad) begin
                        // Rejected operands: report without touching the engine.
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_id    <= gnt_id;
                        resp_data  <= '0;
                        job_bad    <= 1'b0;
                        state      <= ST_RESP;
                    end else if (settle_done && me_finish) begin
                        resp_valid <= 1'b1;
                        resp_id    <= gnt_id;
                        resp_data  <= me_result;
                        state      <= ST_RESP;
                    end else if (tmo_hit) begin
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_id    <= gnt_id;
                        resp_data  <= '0;
                        state      <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    key_abort <= 1'b0;
                    state     <= key_abort ? ST_IDLE : ST_READY;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
